aes_round_key_add: RTL and testbench
====================================

Name: aes_round_key_add

Overview:
- AddRoundKey stage placed directly downstream of the MixColumns stage in the iterative AES-128 encryption datapath.
- XORs each incoming 128-bit state with the current round key, then expands the next round key on the fly.
- Tracks the round index (0..NR). Flags the final round so the round controller can bypass MixColumns.
- Uses a valid/ready handshake on both sides. Holds one output block.

Parameters:
- NR, 10, number of AES rounds; key expansion wraps after round NR (AES-128 only, so NR=10 is the supported value).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- key_load  input  1  one-cycle pulse that loads key_in as the cipher key
- key_in  input  128  cipher key, byte 0 in bits [127:120]
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  128  state from the upstream stage, column-major, byte 0 in bits [127:120]
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  in_data XOR current round key
- out_round  output  4  round index used for out_data
- out_last  output  1  out_data was produced with round NR's key

Behaviour:
- Reset outputs: out_valid=0, out_data=0, out_round=0, out_last=0, in_ready=0.
- Reset internals: key_ok=0, state=IDLE, round=0, rcon=8'h01.
- States:
  - IDLE: waiting for a block.
  - EXPAND: computing the next round key.
- key_load, in any state:
  - cipher_key, rk <= key_in; round <= 0; rcon <= 8'h01; key_ok <= 1; state <= IDLE.
  - Aborts any EXPAND in progress.
  - Does not change out_valid or out_data.
- in_ready = (state==IDLE) & key_ok & ~key_load & (~out_valid | out_ready). This is combinational.
- Accept condition: in_valid & in_ready. On accept:
  - out_data <= in_data ^ rk; out_round <= round; out_last <= (round==NR); out_valid <= 1.
  - state <= EXPAND.
- Latency: 1 cycle from accept to out_valid. Throughput: one block per 2 cycles.
- Output handshake:
  - out_valid & out_ready with no new accept in the same cycle -> out_valid <= 0.
  - An accept in the same cycle as out_ready replaces the output (pass-through, no bubble).
  - out_data stays stable while out_valid=1 and out_ready=0.
- EXPAND, one cycle, then state <= IDLE:
  - round < NR:
    - Let w0..w3 be the words of rk and t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
    - New words: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
    - round <= round+1.
    - rcon <= xtime(rcon), i.e. 01,02,04,...,80,1b,36.
  - round == NR (wrap): rk <= cipher_key; round <= 0; rcon <= 8'h01. The next block starts a new encryption.
- key_load and in_valid in the same cycle: key_load wins; the block is not accepted.
- Reset mid-operation: all state is lost; key_ok=0, so a key_load is required before any block is accepted.

Optional Feature:
- Macro: AES_ROUND_KEY_ADD_RK_OUT_EN
- Defined: adds output port out_rk, 128 bits, registered alongside out_data. It carries the round key used for that block, for debug and scoreboarding.
- Undefined: no out_rk port and no out_rk register.

Decomposition:
- Shared package aes_pkg:
  - state_t (128-bit) and word_t (32-bit) typedefs.
  - AES_NR = 10, RCON_INIT = 8'h01.
  - Functions xtime, rot_word, sub_word.
  - The 256-entry SBOX constant, also used by SubBytes.
- One natural sub-module: aes_key_expand_step, combinational, (rk, rcon) -> (next_rk, next_rcon). Four S-box lookups.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3243f6a8885a308d313198a2e0370734 -> out_data 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0, one cycle after accept.
- Feed 11 zero blocks back to back -> out_data equals the round keys:
  - round 1: a0fafe1788542cb123a339392a6c7605.
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6, with out_last=1.
  - The 12th block gets round 0 again (2b7e...4f3c).
- Hold out_ready=0 with out_valid=1 -> in_ready=0, out_data stable for 5 cycles. Release out_ready with in_valid high -> new block accepted in the same cycle, no gap.
- Assert key_load during EXPAND after round 3 -> next block uses round 0 (the new key). Pending out_data is unchanged.
- key_load and in_valid in the same cycle -> block not accepted. The block is accepted on the following cycle with the round-0 key.
- Assert rst mid-sequence, then present in_valid without a key_load -> in_ready stays 0 and out_valid stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte/word helpers.
// The same S-box table also serves the SubBytes stage.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } rka_state_e;

  localparam int unsigned AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  // Byte 0x00 occupies the top byte, so a lookup indexes from the MSB end.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    logic [10:0] base;
    base = {8'hff - b, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
            sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_round_key_add_if.sv
// Input/output handshake and key-load bundle for aes_round_key_add.
// Optional out_rk exists only when AES_ROUND_KEY_ADD_RK_OUT_EN is defined.
interface aes_round_key_add_if;
  import aes_pkg::*;

  logic       key_load;
  state_t     key_in;
  logic       in_valid;
  logic       in_ready;
  state_t     in_data;
  logic       out_valid;
  logic       out_ready;
  state_t     out_data;
  logic [3:0] out_round;
  logic       out_last;
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
  state_t     out_rk;
`endif

  modport slave (
    input  key_load, key_in, in_valid, in_data, out_ready,
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
    output out_rk,
`endif
    output in_ready, out_valid, out_data, out_round, out_last
  );

  modport master (
    output key_load, key_in, in_valid, in_data, out_ready,
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
    input  out_rk,
`endif
    input  in_ready, out_valid, out_data, out_round, out_last
  );

endinterface

// File: rtl/aes_round_key_add_key_expand_step.sv
// One AES-128 key-schedule step: (rk, rcon) -> (next_rk, next_rcon).
// Purely combinational; four S-box lookups via sub_word.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  state_t     rk,
  input  logic [7:0] rcon,
  output state_t     next_rk,
  output logic [7:0] next_rcon
);

  word_t w0, w1, w2, w3, t;
  word_t n0, n1, n2, n3;

  // Chained word XORs of the AES-128 schedule.
  always_comb begin
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_rk   = {n0, n1, n2, n3};
    next_rcon = xtime(rcon);
  end

endmodule

// File: rtl/aes_round_key_add.sv
// AddRoundKey stage with on-the-fly AES-128 key expansion and a one-deep output register.
// Optional macro AES_ROUND_KEY_ADD_RK_OUT_EN adds the registered out_rk debug port.
module aes_round_key_add
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
)(
  input  logic                    clk,
  input  logic                    rst,
  aes_round_key_add_if.slave      bus
);

  localparam logic [3:0] NR_W = 4'(NR);

  rka_state_e state_q, state_d;
  logic       key_ok_q, key_ok_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  state_t     rk_q, rk_d;
  state_t     cipher_key_q, cipher_key_d;
  logic       out_valid_q, out_valid_d;
  state_t     out_data_q, out_data_d;
  logic [3:0] out_round_q, out_round_d;
  logic       out_last_q, out_last_d;
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
  state_t     out_rk_q, out_rk_d;
`endif

  state_t     exp_rk_s;
  logic [7:0] exp_rcon_s;
  logic       in_ready_s;
  logic       accept_s;

  aes_key_expand_step u_expand (
    .rk        (rk_q),
    .rcon      (rcon_q),
    .next_rk   (exp_rk_s),
    .next_rcon (exp_rcon_s)
  );

  // key_load blocks acceptance so a block never pairs with a stale key.
  assign in_ready_s = (state_q == ST_IDLE) & key_ok_q & ~bus.key_load
                    & (~out_valid_q | bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_ok_q     <= 1'b0;
      round_q      <= 4'd0;
      rcon_q       <= RCON_INIT;
      rk_q         <= 128'h0;
      cipher_key_q <= 128'h0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 128'h0;
      out_round_q  <= 4'd0;
      out_last_q   <= 1'b0;
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
      out_rk_q     <= 128'h0;
`endif
    end else begin
      state_q      <= state_d;
      key_ok_q     <= key_ok_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      rk_q         <= rk_d;
      cipher_key_q <= cipher_key_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_round_q  <= out_round_d;
      out_last_q   <= out_last_d;
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
      out_rk_q     <= out_rk_d;
`endif
    end
  end

  // Next-state: accept moves to EXPAND for one cycle; key_load always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.key_load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = accept_s ? ST_EXPAND : ST_IDLE;
        ST_EXPAND: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Key schedule: load, advance one round, or wrap back to the cipher key after round NR.
  always_comb begin
    key_ok_d     = key_ok_q;
    round_d      = round_q;
    rcon_d       = rcon_q;
    rk_d         = rk_q;
    cipher_key_d = cipher_key_q;
    if (bus.key_load) begin
      key_ok_d     = 1'b1;
      round_d      = 4'd0;
      rcon_d       = RCON_INIT;
      rk_d         = bus.key_in;
      cipher_key_d = bus.key_in;
    end else if (state_q == ST_EXPAND) begin
      if (round_q == NR_W) begin
        round_d = 4'd0;
        rcon_d  = RCON_INIT;
        rk_d    = cipher_key_q;
      end else begin
        round_d = round_q + 4'd1;
        rcon_d  = exp_rcon_s;
        rk_d    = exp_rk_s;
      end
    end else begin
      rk_d = rk_q;
    end
  end

  // Output register: a new accept replaces the held block even in the drain cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
    out_rk_d    = out_rk_q;
`endif
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data ^ rk_q;
      out_round_d = round_q;
      out_last_d  = (round_q == NR_W);
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
      out_rk_d    = rk_q;
`endif
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
  assign bus.out_rk    = out_rk_q;
`endif

endmodule

// File: tb/tb_aes_round_key_add.sv
// Directed bench for aes_round_key_add using FIPS-197 AES-128 key schedule vectors.
module tb_aes_round_key_add;
  import aes_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  aes_round_key_add_if bus();

  aes_round_key_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    logic [3:0]   rnd;
    logic         last;
  } vec_t;

  vec_t vecs [12];

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    chk("in_ready_wait", {127'h0, bus.in_ready}, 128'h1);
  endtask

  initial begin
    int w;
    logic [127:0] held;
    n_checks = 0;
    n_pass   = 0;

    vecs[0]  = '{PT,    CT0,  4'd0,  1'b0};
    vecs[1]  = '{128'h0, RK1, 4'd1,  1'b0};
    vecs[2]  = '{128'h0, RK2, 4'd2,  1'b0};
    vecs[3]  = '{128'h0, RK3, 4'd3,  1'b0};
    vecs[4]  = '{128'h0, 128'hef44a541a8525b7fb671253bdb0bad00, 4'd4,  1'b0};
    vecs[5]  = '{128'h0, 128'hd4d1c6f87c839d87caf2b8bc11f915bc, 4'd5,  1'b0};
    vecs[6]  = '{128'h0, 128'h6d88a37a110b3efddbf98641ca0093fd, 4'd6,  1'b0};
    vecs[7]  = '{128'h0, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 4'd7,  1'b0};
    vecs[8]  = '{128'h0, 128'head27321b58dbad2312bf5607f8d292f, 4'd8,  1'b0};
    vecs[9]  = '{128'h0, 128'hac7766f319fadc2128d12941575c006e, 4'd9,  1'b0};
    vecs[10] = '{128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b1};
    vecs[11] = '{{128{1'b1}}, 128'hd481eae9d7512d595408ea77f630b0c3, 4'd0, 1'b0};

    rst          = 1'b1;
    bus.key_load = 1'b0;
    bus.key_in   = 128'h0;
    bus.in_valid = 1'b0;
    bus.in_data  = 128'h0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {127'h0, bus.out_valid}, 128'h0);
    chk("rst_out_data",  bus.out_data, 128'h0);
    chk("rst_out_round", {124'h0, bus.out_round}, 128'h0);
    chk("rst_out_last",  {127'h0, bus.out_last}, 128'h0);
    chk("rst_in_ready",  {127'h0, bus.in_ready}, 128'h0);
    rst = 1'b0;

    bus.key_load = 1'b1;
    bus.key_in   = KEY;
    tick();
    bus.key_load = 1'b0;

    // Table: FIPS-197 block, round keys 1..10 from zero blocks, then wrap to round 0.
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].din;
      #1;
      wait_ready(w);
      chk($sformatf("throughput_%0d", i), {127'h0, (w < 2)}, 128'h1);
      tick();
      if (i == 11) begin
        bus.out_ready = 1'b0;
        bus.in_data   = 128'h0;
      end
      chk($sformatf("valid_%0d", i), {127'h0, bus.out_valid}, 128'h1);
      chk($sformatf("data_%0d", i),  bus.out_data, vecs[i].dout);
      chk($sformatf("round_%0d", i), {124'h0, bus.out_round}, {124'h0, vecs[i].rnd});
      chk($sformatf("last_%0d", i),  {127'h0, bus.out_last}, {127'h0, vecs[i].last});
`ifdef AES_ROUND_KEY_ADD_RK_OUT_EN
      chk($sformatf("rk_%0d", i), bus.out_rk, vecs[i].dout ^ vecs[i].din);
`endif
    end

    // Backpressure: output held, no accept while stalled.
    held = vecs[11].dout;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_in_ready",  {127'h0, bus.in_ready}, 128'h0);
      chk("hold_out_valid", {127'h0, bus.out_valid}, 128'h1);
      chk("hold_out_data",  bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {127'h0, bus.in_ready}, 128'h1);
    tick();
    chk("release_valid", {127'h0, bus.out_valid}, 128'h1);
    chk("release_data",  bus.out_data, RK1);
    chk("release_round", {124'h0, bus.out_round}, 128'h1);

    // Rounds 2 and 3, then key_load during the EXPAND that follows round 3.
    wait_ready(w);
    tick();
    chk("r2_data", bus.out_data, RK2);
    wait_ready(w);
    tick();
    chk("r3_data", bus.out_data, RK3);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.key_load  = 1'b1;
    bus.key_in    = KEY2;
    tick();
    bus.key_load = 1'b0;
    chk("kl_pending_valid", {127'h0, bus.out_valid}, 128'h1);
    chk("kl_pending_data",  bus.out_data, RK3);
    chk("kl_pending_round", {124'h0, bus.out_round}, 128'h3);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 128'h0;
    #1;
    chk("kl_in_ready", {127'h0, bus.in_ready}, 128'h1);
    tick();
    chk("kl_new_data",  bus.out_data, KEY2);
    chk("kl_new_round", {124'h0, bus.out_round}, 128'h0);

    // key_load and in_valid together: key_load wins, block accepted next cycle.
    bus.in_valid = 1'b0;
    tick();
    bus.key_load = 1'b1;
    bus.key_in   = KEY;
    bus.in_valid = 1'b1;
    bus.in_data  = PT;
    #1;
    chk("coll_in_ready", {127'h0, bus.in_ready}, 128'h0);
    tick();
    chk("coll_not_accepted", {127'h0, bus.out_valid}, 128'h0);
    bus.key_load = 1'b0;
    #1;
    chk("coll_next_ready", {127'h0, bus.in_ready}, 128'h1);
    tick();
    chk("coll_valid", {127'h0, bus.out_valid}, 128'h1);
    chk("coll_data",  bus.out_data, CT0);
    chk("coll_round", {124'h0, bus.out_round}, 128'h0);

    // Reset mid-sequence: no block accepted until a new key_load.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("postrst_in_ready",  {127'h0, bus.in_ready}, 128'h0);
      chk("postrst_out_valid", {127'h0, bus.out_valid}, 128'h0);
      tick();
    end
    chk("postrst_out_data", bus.out_data, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
